miter_obi_arbiter: RTL and testbench

Two-requester OBI arbiter used in the dual-core equivalence miter to share one memory port between the `_1` and `_2` core copies (instruction or data side; one instance per side). It picks between the two A-phase requests round-robin and holds that choice until the pending request is granted. It tags each accepted transfer in an in-order route FIFO so every R-phase response returns to the requester that issued it. It also flags protocol violations on the shared response side.

---
 rtl/miter_obi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_miter_obi_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miter_obi_arbiter.sv
// Two-requester OBI arbiter for the dual-core miter: round-robin A-phase selection with
// hold-until-grant, plus an in-order route FIFO that steers R-phase responses back to their issuer.
module miter_obi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r1_req,
  input  logic                       r2_req,
  output logic                       r1_gnt,
  output logic                       r2_gnt,
  input  logic [ADDR_W-1:0]          r1_addr,
  input  logic [ADDR_W-1:0]          r2_addr,
  input  logic                       r1_we,
  input  logic                       r2_we,
  input  logic [DATA_W/8-1:0]        r1_be,
  input  logic [DATA_W/8-1:0]        r2_be,
  input  logic [DATA_W-1:0]          r1_wdata,
  input  logic [DATA_W-1:0]          r2_wdata,
  output logic                       r1_rvalid,
  output logic                       r2_rvalid,
  output logic [DATA_W-1:0]          r1_rdata,
  output logic [DATA_W-1:0]          r2_rdata,
  output logic                       r1_err,
  output logic                       r2_err,
  output logic                       m_req,
  input  logic                       m_gnt,
  output logic [ADDR_W-1:0]          m_addr,
  output logic                       m_we,
  output logic [DATA_W/8-1:0]        m_be,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_rvalid,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_err,
  output logic                       proto_err,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ID_R1 = 1'b0, ID_R2 = 1'b1} req_id_e;

  req_id_e          prio_q, prio_d;
  logic             lock_q, lock_d;
  req_id_e          lock_id_q, lock_id_d;
  req_id_e          fifo_q [DEPTH];
  req_id_e          fifo_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             proto_err_q, proto_err_d;

  logic             sel_valid, sel_req, fifo_full, fifo_empty, push, pop;
  req_id_e          sel_id, head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = ID_R1;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_id    = lock_id_q;
    end else if (r1_req && r2_req) begin
      sel_valid = 1'b1;
      sel_id    = prio_q;
    end else if (r1_req) begin
      sel_valid = 1'b1;
      sel_id    = ID_R1;
    end else if (r2_req) begin
      sel_valid = 1'b1;
      sel_id    = ID_R2;
    end
  end

  assign sel_req    = sel_valid && ((sel_id == ID_R2) ? r2_req : r1_req);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_q[rd_ptr_q];

  // Full blocks the request outright; a same-cycle pop never frees a slot, keeping m_rvalid off m_req.
  assign m_req = !rst && sel_req && !fifo_full;
  assign push  = m_req && m_gnt;
  assign pop   = !rst && m_rvalid && !fifo_empty;

  always_comb begin
    m_addr    = '0;
    m_we      = 1'b0;
    m_be      = '0;
    m_wdata   = '0;
    if (!rst && sel_valid) begin
      m_addr  = (sel_id == ID_R2) ? r2_addr  : r1_addr;
      m_we    = (sel_id == ID_R2) ? r2_we    : r1_we;
      m_be    = (sel_id == ID_R2) ? r2_be    : r1_be;
      m_wdata = (sel_id == ID_R2) ? r2_wdata : r1_wdata;
    end
  end

  assign r1_gnt      = push && (sel_id == ID_R1);
  assign r2_gnt      = push && (sel_id == ID_R2);
  assign r1_rvalid   = pop && (head_id == ID_R1);
  assign r2_rvalid   = pop && (head_id == ID_R2);
  assign r1_rdata    = r1_rvalid ? m_rdata : '0;
  assign r2_rdata    = r2_rvalid ? m_rdata : '0;
  assign r1_err      = r1_rvalid && m_err;
  assign r2_err      = r2_rvalid && m_err;
  assign proto_err   = !rst && proto_err_q;
  assign outstanding = rst ? '0 : count_q;

  always_comb begin
    prio_d    = push ? req_id_e'(~sel_id) : prio_q;
    // Lock only while a request is stalled; a retracted locked request drops the lock to avoid starvation.
    lock_d    = m_req && !m_gnt;
    lock_id_d = lock_d ? sel_id : lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    proto_err_d = proto_err_q || (m_rvalid && fifo_empty) || (lock_q && !sel_req);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= ID_R1;
      lock_q      <= 1'b0;
      lock_id_q   <= ID_R1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: route storage is not reset; entries are only read below count_q, which is reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_miter_obi_arbiter.sv
// Directed self-checking bench for miter_obi_arbiter: arbitration, lock, routing, full FIFO,
// protocol-error and mid-operation reset scenarios with hand-computed expectations.
module tb_miter_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r1_req, r2_req, r1_gnt, r2_gnt;
  logic [31:0] r1_addr, r2_addr;
  logic        r1_we, r2_we;
  logic [3:0]  r1_be, r2_be;
  logic [31:0] r1_wdata, r2_wdata;
  logic        r1_rvalid, r2_rvalid;
  logic [31:0] r1_rdata, r2_rdata;
  logic        r1_err, r2_err;
  logic        m_req, m_gnt;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        proto_err;
  logic [1:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miter_obi_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .r1_req(r1_req), .r2_req(r2_req), .r1_gnt(r1_gnt), .r2_gnt(r2_gnt),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_we(r1_we), .r2_we(r2_we),
    .r1_be(r1_be), .r2_be(r2_be), .r1_wdata(r1_wdata), .r2_wdata(r2_wdata),
    .r1_rvalid(r1_rvalid), .r2_rvalid(r2_rvalid), .r1_rdata(r1_rdata), .r2_rdata(r2_rdata),
    .r1_err(r1_err), .r2_err(r2_err),
    .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .proto_err(proto_err), .outstanding(outstanding)
  );

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    r1_req = 0; r2_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0; m_err = 0;
  endtask

  task automatic test_reset();
    rst = 1; r1_req = 1; r2_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
    settle();
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", {r1_gnt, r2_gnt}); end
    n_checks++; if ({r1_rvalid, r2_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {r1_rvalid, r2_rvalid}); end
    n_checks++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
    step(); step();
    rst = 0; idle_inputs();
    settle();
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    n_checks++; if (m_addr !== 32'h0 || m_req !== 1'b0) begin n_fail++; $display("FAIL idle_payload got addr=%h req=%b exp=0/0", m_addr, m_req); end
  endtask

  task automatic test_simultaneous_and_full();
    r1_addr = 32'h0000_0100; r2_addr = 32'h0000_0200;
    r1_req = 1; r2_req = 1; m_gnt = 1;
    settle();
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b10) begin n_fail++; $display("FAIL sim_c0_gnt got=%b exp=10", {r1_gnt, r2_gnt}); end
    n_checks++; if (m_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL sim_c0_addr got=%h exp=00000100", m_addr); end
    step();
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b01) begin n_fail++; $display("FAIL sim_c1_gnt got=%b exp=01", {r1_gnt, r2_gnt}); end
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL sim_c1_outstanding got=%0d exp=1", outstanding); end
    step();
    n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL sim_c2_outstanding got=%0d exp=2", outstanding); end
    n_checks++; if (m_req !== 1'b0 || {r1_gnt, r2_gnt} !== 2'b00) begin n_fail++; $display("FAIL sim_full_block got req=%b gnt=%b exp=0/00", m_req, {r1_gnt, r2_gnt}); end
    // Full FIFO with a response popping: still no grant this cycle.
    m_rvalid = 1; m_rdata = 32'h1111_1111;
    settle();
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_bypass got=%b exp=0", m_req); end
    n_checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h1111_1111 || r2_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_route got r1v=%b r1d=%h r2v=%b exp=1/11111111/0", r1_rvalid, r1_rdata, r2_rvalid);
    end
    step();
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL after_pop_outstanding got=%0d exp=1", outstanding); end
    n_checks++; if (m_req !== 1'b1 || {r1_gnt, r2_gnt} !== 2'b10) begin n_fail++; $display("FAIL after_pop_grant got req=%b gnt=%b exp=1/10", m_req, {r1_gnt, r2_gnt}); end
    // Pop of r2's response coincides with r1's push: occupancy unchanged.
    m_rdata = 32'h2222_2222;
    settle();
    n_checks++; if (r2_rvalid !== 1'b1 || r2_rdata !== 32'h2222_2222 || r1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL push_pop_route got r2v=%b r2d=%h r1v=%b exp=1/22222222/0", r2_rvalid, r2_rdata, r1_rvalid);
    end
    step();
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL push_pop_count got=%0d exp=1", outstanding); end
    r1_req = 0; r2_req = 0; m_gnt = 0; m_rdata = 32'h3333_3333;
    settle();
    n_checks++; if (r1_rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_r1 got=%b exp=1", r1_rvalid); end
    step();
    idle_inputs();
    settle();
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", outstanding); end
  endtask

  task automatic test_lock();
    r1_addr = 32'h0000_0100; r2_addr = 32'h0000_1000;
    r2_we = 1; r2_be = 4'hF; r2_wdata = 32'hDEAD_BEEF;
    r2_req = 1; m_gnt = 0;
    settle();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lock_c0 got req=%b addr=%h exp=1/00001000", m_req, m_addr); end
    step();
    r1_req = 1;
    settle();
    n_checks++; if (m_addr !== 32'h0000_1000 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_c1 got addr=%h r1_gnt=%b exp=00001000/0", m_addr, r1_gnt); end
    step();
    n_checks++; if (m_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lock_c2 got addr=%h exp=00001000", m_addr); end
    step();
    m_gnt = 1;
    settle();
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b01 || m_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lock_c3 got gnt=%b addr=%h exp=01/00001000", {r1_gnt, r2_gnt}, m_addr); end
    n_checks++; if (m_we !== 1'b1 || m_be !== 4'hF || m_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lock_payload got we=%b be=%h wd=%h exp=1/f/deadbeef", m_we, m_be, m_wdata);
    end
    step();
    r2_req = 0;
    settle();
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b10 || m_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lock_next_r1 got gnt=%b addr=%h exp=10/00000100", {r1_gnt, r2_gnt}, m_addr); end
    step();
    idle_inputs();
    m_rvalid = 1;
    settle();
    n_checks++; if (r2_rvalid !== 1'b1) begin n_fail++; $display("FAIL lock_drain_r2 got=%b exp=1", r2_rvalid); end
    step();
    settle();
    n_checks++; if (r1_rvalid !== 1'b1) begin n_fail++; $display("FAIL lock_drain_r1 got=%b exp=1", r1_rvalid); end
    step();
    idle_inputs();
    r2_we = 0; r2_be = '0; r2_wdata = '0;
  endtask

  task automatic test_routing();
    r1_addr = 32'h10; r2_addr = 32'h20;
    r1_req = 1; m_gnt = 1;
    settle();
    n_checks++; if (r1_gnt !== 1'b1 || m_addr !== 32'h10) begin n_fail++; $display("FAIL route_acc_r1 got gnt=%b addr=%h exp=1/10", r1_gnt, m_addr); end
    step();
    r1_req = 0; r2_req = 1;
    settle();
    n_checks++; if (r2_gnt !== 1'b1 || m_addr !== 32'h20) begin n_fail++; $display("FAIL route_acc_r2 got gnt=%b addr=%h exp=1/20", r2_gnt, m_addr); end
    step();
    r2_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hAAAA_AAAA;
    settle();
    n_checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hAAAA_AAAA || r1_err !== 1'b0) begin
      n_fail++; $display("FAIL route_resp1 got v=%b d=%h e=%b exp=1/aaaaaaaa/0", r1_rvalid, r1_rdata, r1_err);
    end
    n_checks++; if (r2_rvalid !== 1'b0 || r2_rdata !== 32'h0) begin n_fail++; $display("FAIL route_resp1_other got v=%b d=%h exp=0/0", r2_rvalid, r2_rdata); end
    step();
    m_rdata = 32'hBBBB_BBBB; m_err = 1;
    settle();
    n_checks++; if (r2_rvalid !== 1'b1 || r2_rdata !== 32'hBBBB_BBBB || r2_err !== 1'b1) begin
      n_fail++; $display("FAIL route_resp2 got v=%b d=%h e=%b exp=1/bbbbbbbb/1", r2_rvalid, r2_rdata, r2_err);
    end
    n_checks++; if (r1_rvalid !== 1'b0 || r1_err !== 1'b0) begin n_fail++; $display("FAIL route_resp2_other got v=%b e=%b exp=0/0", r1_rvalid, r1_err); end
    step();
    idle_inputs();
    settle();
    n_checks++; if (outstanding !== 2'd0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL route_end got out=%0d perr=%b exp=0/0", outstanding, proto_err); end
  endtask

  task automatic pulse_reset();
    rst = 1; idle_inputs();
    step();
    rst = 0;
    settle();
  endtask

  task automatic test_proto_empty();
    m_rvalid = 1; m_rdata = 32'h5555_5555;
    settle();
    n_checks++; if ({r1_rvalid, r2_rvalid} !== 2'b00 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL perr_empty_now got rv=%b perr=%b exp=00/0", {r1_rvalid, r2_rvalid}, proto_err);
    end
    step();
    m_rvalid = 0;
    settle();
    n_checks++; if (proto_err !== 1'b1 || outstanding !== 2'd0) begin n_fail++; $display("FAIL perr_empty_set got perr=%b out=%0d exp=1/0", proto_err, outstanding); end
    step(); step();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    rst = 1;
    settle();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_rst_comb got=%b exp=0", proto_err); end
    step();
    rst = 0;
    step();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_cleared got=%b exp=0", proto_err); end
  endtask

  task automatic test_proto_retract();
    r1_req = 1; m_gnt = 0;
    step();
    r1_req = 0;
    settle();
    n_checks++; if (m_req !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL retract_now got req=%b perr=%b exp=0/0", m_req, proto_err); end
    step();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL retract_perr got=%b exp=1", proto_err); end
    pulse_reset();
  endtask

  task automatic test_mid_reset();
    // Two back-to-back r1 accepts leave prio pointing at r2 and the FIFO full.
    r1_req = 1; m_gnt = 1;
    step(); step();
    n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL mid_fill got=%0d exp=2", outstanding); end
    rst = 1; r2_req = 1; m_rvalid = 1;
    settle();
    n_checks++; if ({m_req, r1_gnt, r2_gnt, r1_rvalid, r2_rvalid, proto_err} !== 6'b0 || outstanding !== 2'd0 || m_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_outputs got req=%b gnt=%b%b rv=%b%b perr=%b out=%0d addr=%h exp=all 0",
                         m_req, r1_gnt, r2_gnt, r1_rvalid, r2_rvalid, proto_err, outstanding, m_addr);
    end
    step();
    rst = 0; m_rvalid = 0;
    settle();
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL mid_rel_outstanding got=%0d exp=0", outstanding); end
    n_checks++; if ({r1_gnt, r2_gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_rel_first_gnt got=%b exp=10", {r1_gnt, r2_gnt}); end
    step();
    idle_inputs();
    m_rvalid = 1;
    step();
    m_rvalid = 0;
    step();
    // One accept after release, then two responses: the second arrives with the FIFO empty.
    m_rvalid = 1;
    step();
    m_rvalid = 0;
    settle();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL mid_stale_resp_perr got=%b exp=1", proto_err); end
  endtask

  initial begin
    rst = 1; idle_inputs();
    r1_addr = '0; r2_addr = '0; r1_we = 0; r2_we = 0; r1_be = '0; r2_be = '0;
    r1_wdata = '0; r2_wdata = '0;
    #2;
    test_reset();
    test_simultaneous_and_full();
    test_lock();
    test_routing();
    test_proto_empty();
    test_proto_retract();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
